uart_tx_scheduler: RTL and testbench

//  Shares the board's single UART TX pin between NUM_REQ byte producers (debug, status, boot log).
//  - Arbitrates round-robin between the producers.
//  - Serialises the granted byte as 8N1, LSB first, and drives uart_tx.
//  - Sits between the producer logic in the top level and the uart_tx pad, in the clk48 domain.

---
 rtl/uart_tx_scheduler_if.sv | 29 ++
 rtl/uart_tx_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if
//   Groups the byte-producer handshake and the scheduler status signals shared
//   between the producers and uart_tx_scheduler.
//   Signals:
//     req_valid  [NUM_REQ]    per-requester byte-valid (producer -> scheduler)
//     req_data   [8*NUM_REQ]  byte for requester i at [8*i+7:8*i]
//     req_ready  [NUM_REQ]    one-hot accept strobe (scheduler -> producer)
//     grant_id   [3]          owner of the current or last frame
//     busy                    frame in progress
//   Modports: master = producer side, slave = scheduler side.
interface uart_tx_scheduler_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [2:0]           grant_id;
  logic                 busy;

  modport master (
    output req_valid, req_data,
    input  req_ready, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one UART TX pin between NUM_REQ byte producers. Round-robin
//   arbitration in IDLE, then the granted byte is serialised 8N1, LSB first.
//   Ports:
//     clk48    system clock, all logic on posedge
//     rst      synchronous active-high reset
//     bus      uart_tx_scheduler_if.slave (req_valid/req_data/req_ready/
//              grant_id/busy)
//     uart_tx  serial output, idle high, driven from a flop
//   Build option: UART_TX_PARITY_EN adds an even-parity bit between the data
//   bits and the stop bit (frame becomes 11 bit times).
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned CLKS_PER_BIT = 416
) (
  input  logic                 clk48,
  input  logic                 rst,
  uart_tx_scheduler_if.slave   bus,
  output logic                 uart_tx
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic [2:0]           grant_q, grant_d;
  logic [2:0]           rr_q, rr_d;

  logic                 found;
  logic [2:0]           cand;
  int unsigned          idx;
  logic [NUM_REQ-1:0]   vshift;
  logic [8*NUM_REQ-1:0] dshift;
  logic [7:0]           cand_byte;
  logic                 last;

  // Search from rr_ptr+1 upward with wrap; the first valid requester wins.
  always_comb begin
    found  = 1'b0;
    cand   = '0;
    idx    = 0;
    vshift = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx    = (32'(rr_q) + i) % NUM_REQ;
      vshift = bus.req_valid >> idx;
      if (!found && vshift[0]) begin
        found = 1'b1;
        cand  = 3'(idx);
      end
    end
  end

  always_comb begin
    dshift    = bus.req_data >> {cand, 3'b000};
    cand_byte = dshift[7:0];
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == S_IDLE && found && !rst)
      bus.req_ready = NUM_REQ'(1) << cand;
  end

  assign last = (cnt_q == CW'(CLKS_PER_BIT - 1));

  // tx_d is the line level for the following cycle, so every transition
  // loads the first level of the state being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        tx_d  = 1'b1;
        if (found) begin
          shift_d = cand_byte;
          par_d   = ^cand_byte;
          grant_d = cand;
          rr_d    = cand;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (last) begin
          cnt_d   = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (last) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (last) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (last) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      grant_q <= '0;
      rr_q    <= 3'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  assign uart_tx      = tx_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with NUM_REQ=2, CLKS_PER_BIT=416.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx_scheduler;

  localparam int unsigned NR  = 2;
  localparam int unsigned CPB = 416;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NB  = 11;
`else
  localparam int unsigned NB  = 10;
`endif

  logic clk48 = 1'b0;
  logic rst   = 1'b1;
  logic uart_tx;

  int n_chk  = 0;
  int n_fail = 0;

  uart_tx_scheduler_if #(.NUM_REQ(NR)) bus ();

  uart_tx_scheduler #(.NUM_REQ(NR), .CLKS_PER_BIT(CPB)) dut (
    .clk48   (clk48),
    .rst     (rst),
    .bus     (bus),
    .uart_tx (uart_tx)
  );

  always #5 clk48 = ~clk48;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge in IDLE with the winning request already driven.
  // Returns at the falling edge of the first IDLE cycle after the frame.
  task automatic frame(input logic [7:0] exp, input logic [2:0] gid,
                       input logic [7:0] mid_d0);
    int   busy_cnt;
    logic ebit;
    busy_cnt = 0;
    #1;
    chk("ready_onehot", 32'(bus.req_ready), 32'(1) << gid);
    for (int cyc = 1; cyc <= int'(NB * CPB); cyc++) begin
      @(negedge clk48);
      if (bus.busy === 1'b1) busy_cnt++;
      if (cyc == 1) begin
        chk("grant_id", 32'(bus.grant_id), 32'(gid));
        chk("ready_low_busy", 32'(bus.req_ready), 32'(0));
      end
      if (cyc == 1000) bus.req_data[7:0] = mid_d0;
      if (cyc % int'(CPB) == int'(CPB / 2)) begin
        int b;
        b = cyc / int'(CPB);
        if (b == 0)                      ebit = 1'b0;
        else if (b <= 8)                 ebit = exp[b-1];
        else if (b == int'(NB) - 1)      ebit = 1'b1;
        else                             ebit = ^exp;
        chk($sformatf("bit%0d", b), 32'(uart_tx), 32'(ebit));
      end
    end
    chk("busy_len", 32'(busy_cnt), 32'(NB * CPB));
    @(negedge clk48);
    chk("busy_end", 32'(bus.busy), 32'(0));
    chk("tx_idle", 32'(uart_tx), 32'(1));
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;

    // 1: reset, then long idle with no requests.
    repeat (3) @(negedge clk48);
    rst = 1'b0;
    for (int i = 1; i <= 5000; i++) begin
      @(negedge clk48);
      if (i % 1000 == 0) begin
        chk("idle_tx", 32'(uart_tx), 32'(1));
        chk("idle_busy", 32'(bus.busy), 32'(0));
        chk("idle_ready", 32'(bus.req_ready), 32'(0));
        chk("idle_grant", 32'(bus.grant_id), 32'(0));
      end
    end

    // 2: single requester, 0x55 alternating pattern.
    bus.req_valid = 2'b01;
    bus.req_data  = {8'h00, 8'h55};
    frame(8'h55, 3'd0, 8'h55);
    bus.req_valid = 2'b00;

    // 3: both valid after reset -> back-to-back 0, 1, 0.
    rst = 1'b1;
    @(negedge clk48);
    rst = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_data  = {8'h3C, 8'hA5};
    frame(8'hA5, 3'd0, 8'hA5);
    frame(8'h3C, 3'd1, 8'hA5);
    frame(8'hA5, 3'd0, 8'hA5);
    bus.req_valid = 2'b00;

    // 4: reset during data bit 3 of 0xFF; rr pointer must restart at req 0.
    bus.req_valid = 2'b01;
    bus.req_data  = {8'h00, 8'hFF};
    #1;
    chk("ready_ff", 32'(bus.req_ready), 32'(1));
    @(negedge clk48);
    bus.req_valid = 2'b00;
    repeat (1799) @(negedge clk48);
    chk("busy_pre_rst", 32'(bus.busy), 32'(1));
    rst = 1'b1;
    #1;
    chk("ready_in_rst", 32'(bus.req_ready), 32'(0));
    @(negedge clk48);
    rst = 1'b0;
    chk("rst_tx", 32'(uart_tx), 32'(1));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_grant", 32'(bus.grant_id), 32'(0));
    bus.req_valid = 2'b11;
    bus.req_data  = {8'hC3, 8'h81};
    frame(8'h81, 3'd0, 8'h81);
    bus.req_valid = 2'b00;

    // 5: data changed mid-frame must not affect the transmitted byte.
    @(negedge clk48);
    bus.req_valid = 2'b01;
    bus.req_data  = {8'h00, 8'h12};
    frame(8'h12, 3'd0, 8'hEE);
    bus.req_valid = 2'b00;

`ifdef UART_TX_PARITY_EN
    // 6: parity bit for 0x07 is 1.
    @(negedge clk48);
    bus.req_valid = 2'b01;
    bus.req_data  = {8'h00, 8'h07};
    frame(8'h07, 3'd0, 8'h07);
    bus.req_valid = 2'b00;
`endif

    repeat (5) @(negedge clk48);
    chk("final_tx", 32'(uart_tx), 32'(1));
    chk("final_busy", 32'(bus.busy), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
